// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN calculator sequencer.
//   state_e   : sequencer FSM states
//   op_e      : arithmetic operation selector for rpn_alu
//   tok_e     : latched token that decides where a PUSH continues
//   ASCII_*   : byte codes recognised on the receive stream
//   tok_to_op : maps a latched operator token onto an ALU operation
package rpn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_OP   = 3'd2,
    ST_RES  = 3'd3,
    ST_POP  = 3'd4,
    ST_CLR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    TOK_SPACE = 3'd0,
    TOK_ADD   = 3'd1,
    TOK_SUB   = 3'd2,
    TOK_MUL   = 3'd3,
    TOK_EQ    = 3'd4
  } tok_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_LC_C  = 8'h63;
  localparam logic [7:0] ASCII_UC_C  = 8'h43;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  function automatic op_e tok_to_op(input tok_e t);
    case (t)
      TOK_SUB: return OP_SUB;
      TOK_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational arithmetic for the RPN sequencer.
//   op : operation select
//   a  : left operand (entry below the stack top)
//   b  : right operand (stack top)
//   y  : a op b, low WIDTH bits (all operations wrap modulo 2^WIDTH)
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation select; product is truncated by the WIDTH-bit result context.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: token-level sequencer of the RPN calculator.
// Accepts ASCII bytes, accumulates decimal literals, and is the only master
// of the operand stack (push / replace-with-result / pop). Results are
// offered to the TX side with a valid/ready handshake.
//   clk, rst                : clock, asynchronous active-high reset
//   rx_valid/rx_data/rx_ready : incoming byte stream
//   stk_wen/stk_din/stk_pop_cnt : stack command (pop first, then write)
//   stk_first/stk_second    : current top and next entry of the stack
//   res_valid/res_data/res_ready : result handshake
//   err                     : sticky error, cleared only by 'c'/'C'
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             stk_wen,
  output logic [WIDTH-1:0] stk_din,
  output logic [1:0]       stk_pop_cnt,
  input  logic [WIDTH-1:0] stk_first,
  input  logic [WIDTH-1:0] stk_second,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  state_e           state;
  tok_e             tok;
  logic [WIDTH-1:0] acc;
  logic             num_pend;
  logic [DW-1:0]    depth;

  logic             push_ok;
  logic             op_ok;
  logic [1:0]       clr_pop;
  logic             is_digit;
  logic             is_clear;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] alu_y;

  assign push_ok   = (depth < DEPTH_MAX);
  assign op_ok     = (depth >= DW'(2));
  // min(depth, 2): below two entries the low bits already equal depth.
  assign clr_pop   = op_ok ? 2'd2 : depth[1:0];
  assign is_digit  = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign is_clear  = (rx_data == ASCII_LC_C) || (rx_data == ASCII_UC_C);
  // ASCII digits carry their value in the low nibble.
  assign digit_ext = WIDTH'(rx_data[3:0]);

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op (tok_to_op(tok)),
    .a  (stk_second),
    .b  (stk_first),
    .y  (alu_y)
  );

  // Stack command decode from the current state and occupancy.
  always_comb begin
    stk_wen     = 1'b0;
    stk_din     = '0;
    stk_pop_cnt = 2'd0;
    case (state)
      ST_PUSH: begin
        if (push_ok) begin
          stk_wen = 1'b1;
          stk_din = acc;
        end else begin
          stk_wen = 1'b0;
        end
      end
      ST_OP: begin
        if (op_ok) begin
          stk_wen     = 1'b1;
          stk_din     = alu_y;
          stk_pop_cnt = 2'd2;
        end else begin
          stk_wen     = 1'b0;
        end
      end
      ST_POP:  stk_pop_cnt = 2'd1;
      ST_CLR:  stk_pop_cnt = clr_pop;
      default: stk_pop_cnt = 2'd0;
    endcase
  end

  // Handshake decode; reset forces state to IDLE, so res_valid drops at once.
  always_comb begin
    rx_ready  = (state == ST_IDLE);
    res_valid = (state == ST_RES) && (depth != '0);
    if (res_valid) begin
      res_data = stk_first;
    end else begin
      res_data = '0;
    end
  end

  // Sequencer FSM, accumulator, occupancy counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tok      <= TOK_SPACE;
      acc      <= '0;
      num_pend <= 1'b0;
      depth    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (is_clear) begin
              state    <= ST_CLR;
              err      <= 1'b0;
              acc      <= '0;
              num_pend <= 1'b0;
            end else if (err) begin
              state <= ST_IDLE;  // swallowed until cleared
            end else if (is_digit) begin
              acc      <= acc * WIDTH'(10) + digit_ext;
              num_pend <= 1'b1;
            end else if (rx_data == ASCII_SPACE) begin
              tok   <= TOK_SPACE;
              state <= num_pend ? ST_PUSH : ST_IDLE;
            end else if (rx_data == ASCII_PLUS || rx_data == ASCII_MINUS ||
                         rx_data == ASCII_STAR) begin
              tok   <= (rx_data == ASCII_PLUS)  ? TOK_ADD :
                       (rx_data == ASCII_MINUS) ? TOK_SUB : TOK_MUL;
              state <= num_pend ? ST_PUSH : ST_OP;
            end else if (rx_data == ASCII_EQ || rx_data == ASCII_CR) begin
              tok   <= TOK_EQ;
              state <= num_pend ? ST_PUSH : ST_RES;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_PUSH: begin
          acc      <= '0;
          num_pend <= 1'b0;
          if (push_ok) begin
            depth <= depth + DW'(1);
            case (tok)
              TOK_SPACE: state <= ST_IDLE;
              TOK_EQ:    state <= ST_RES;
              default:   state <= ST_OP;
            endcase
          end else begin
            // overflow aborts the rest of the sequence, including any OP
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_OP: begin
          if (op_ok) begin
            depth <= depth - DW'(1);
          end else begin
            err <= 1'b1;
          end
          state <= ST_IDLE;
        end
        ST_RES: begin
          if (depth == '0) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else if (res_ready) begin
            state <= ST_POP;
          end
        end
        ST_POP: begin
          depth <= depth - DW'(1);
          state <= ST_IDLE;
        end
        ST_CLR: begin
          depth <= depth - DW'(clr_pop);
          if (depth == DW'(clr_pop)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: self-checking bench for rpn_ctrl. A behavioural stack model
// answers the stack port; a table of expression strings with hand-computed
// results is run first, followed by directed multi-cycle corner sequences.
module tb_rpn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        stk_wen;
  logic [15:0] stk_din;
  logic [1:0]  stk_pop_cnt;
  logic [15:0] stk_first;
  logic [15:0] stk_second;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rpn_ctrl #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .stk_wen(stk_wen), .stk_din(stk_din), .stk_pop_cnt(stk_pop_cnt),
    .stk_first(stk_first), .stk_second(stk_second),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err(err)
  );

  // ---------------- stack model ----------------
  logic [15:0] mem [0:31];
  int sp;
  int sp_pop;
  int sp_m1;
  int sp_m2;
  assign sp_pop = (sp - int'(stk_pop_cnt) < 0) ? 0 : sp - int'(stk_pop_cnt);
  assign sp_m1  = sp - 1;
  assign sp_m2  = sp - 2;
  assign stk_first  = (sp > 0) ? mem[sp_m1[4:0]] : 16'd0;
  assign stk_second = (sp > 1) ? mem[sp_m2[4:0]] : 16'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else if (stk_wen) begin
      mem[sp_pop[4:0]] <= stk_din;
      sp <= (sp_pop < 31) ? sp_pop + 1 : 31;
    end else begin
      sp <= sp_pop;
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic        wen;
    logic [15:0] din;
    logic [1:0]  pop;
  } ev_t;

  ev_t         ev_q[$];
  logic [15:0] res_q[$];

  always @(negedge clk) begin
    if (!rst && (stk_wen || stk_pop_cnt != 2'd0)) ev_q.push_back('{stk_wen, stk_din, stk_pop_cnt});
    if (!rst && res_valid && res_ready) res_q.push_back(res_data);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("settle", rx_ready, 1);
  endtask

  function automatic int count_wen();
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].wen) c++;
    return c;
  endfunction

  function automatic int count_pop(input logic [1:0] p);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i].pop == p) c++;
    return c;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       s;
    logic [15:0] res;
    int          n_wen;
    int          n_res;
    logic        err;
  } vec_t;

  vec_t vecs[6];
  ev_t  exp_ev[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"12 3+=",     16'd15,    3, 1, 1'b0};
    vecs[1] = '{"5 7-=",      16'd65534, 3, 1, 1'b0};
    vecs[2] = '{"300 300*=",  16'd24464, 3, 1, 1'b0};
    vecs[3] = '{"2 3 4*+=",   16'd14,    5, 1, 1'b0};
    vecs[4] = '{"7=",         16'd7,     1, 1, 1'b0};
    vecs[5] = '{"65535 1+=",  16'd0,     3, 1, 1'b0};

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_rx_ready",  rx_ready,    1);
    check("rst_stk_wen",   stk_wen,     0);
    check("rst_stk_din",   stk_din,     0);
    check("rst_pop_cnt",   stk_pop_cnt, 0);
    check("rst_res_valid", res_valid,   0);
    check("rst_res_data",  res_data,    0);
    check("rst_err",       err,         0);
    rst = 1'b0;

    // table-driven expressions
    foreach (vecs[v]) begin
      ev_q.delete();
      res_q.delete();
      send_str(vecs[v].s);
      settle();
      check({"res_count ", vecs[v].s}, res_q.size(), vecs[v].n_res);
      if (res_q.size() > 0) check({"res_data ", vecs[v].s}, res_q[0], vecs[v].res);
      check({"wen_count ", vecs[v].s}, count_wen(), vecs[v].n_wen);
      check({"err ", vecs[v].s}, err, vecs[v].err);
      check({"depth ", vecs[v].s}, sp, 0);
    end

    // detailed stack traffic for "12 3+="
    exp_ev[0] = '{1'b1, 16'd12, 2'd0};
    exp_ev[1] = '{1'b1, 16'd3,  2'd0};
    exp_ev[2] = '{1'b1, 16'd15, 2'd2};
    exp_ev[3] = '{1'b0, 16'd0,  2'd1};
    ev_q.delete();
    send_str("12 3+=");
    settle();
    check("add_ev_count", ev_q.size(), 4);
    for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
      check("add_ev_wen", ev_q[i].wen, exp_ev[i].wen);
      check("add_ev_din", ev_q[i].din, exp_ev[i].din);
      check("add_ev_pop", ev_q[i].pop, exp_ev[i].pop);
    end

    // underflow, ignored bytes while in error, clear
    ev_q.delete();
    res_q.delete();
    send_str("+");
    settle();
    check("uflow_err", err, 1);
    check("uflow_no_stack", ev_q.size(), 0);
    send_str("4=");
    settle();
    check("err_ignore_stack", ev_q.size(), 0);
    check("err_ignore_res", res_q.size(), 0);
    check("err_still_set", err, 1);
    send_str("c");
    settle();
    check("clear_err", err, 0);
    check("clear_empty_no_stack", ev_q.size(), 0);

    // overflow: 17 pushes, 16 land
    ev_q.delete();
    for (int i = 0; i < 17; i++) send_str("1 ");
    settle();
    check("oflow_wen", count_wen(), 16);
    check("oflow_err", err, 1);
    check("oflow_depth", sp, 16);
    ev_q.delete();
    send_str("c");
    settle();
    check("oflow_clr_pop2", count_pop(2'd2), 8);
    check("oflow_clr_depth", sp, 0);
    check("oflow_clr_err", err, 0);

    // clear with two entries, then '=' on empty stack
    ev_q.delete();
    send_str("2 3 c");
    settle();
    check("clr_ev_count", ev_q.size(), 3);
    check("clr_pop2", count_pop(2'd2), 1);
    check("clr_depth", sp, 0);
    res_q.delete();
    send_str("=");
    settle();
    check("clr_eq_err", err, 1);
    check("clr_eq_no_res", res_q.size(), 0);
    send_str("c");
    settle();

    // reset while holding a result
    @(posedge clk);
    #1 res_ready = 1'b0;
    send_str("8=");
    begin
      int n = 0;
      while (!res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("hold_res_valid", res_valid, 1);
    check("hold_res_data", res_data, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_stable_valid", res_valid, 1);
      check("hold_stable_data", res_data, 8);
      check("hold_rx_ready", rx_ready, 0);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_rx_ready", rx_ready, 1);
    check("rst_mid_res_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_err", err, 0);
    check("post_rst_idle", rx_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
